sram_sp_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of one single-port SRAM macro (active-low CEB/WEB, registered read data, 1-cycle read latency).
- After reset it runs a zero-fill pass over the whole array, then arbitrates read/write commands from two independent clients.
- It returns read data tagged per requester. Sits between the reservoir-state/weight engines and the shared SRAM.

---
 rtl/sram_sp_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_sp_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sp_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port SRAM macro.
// Zero-fills the array after reset, then issues one client command per cycle.
module sram_sp_arbiter #(
    parameter int unsigned bit_length  = 128,
    parameter int unsigned addr_length = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0,
    input  logic                   we0,
    input  logic [addr_length-1:0] addr0,
    input  logic [bit_length-1:0]  wdata0,
    output logic                   gnt0,
    output logic                   rvalid0,
    input  logic                   req1,
    input  logic                   we1,
    input  logic [addr_length-1:0] addr1,
    input  logic [bit_length-1:0]  wdata1,
    output logic                   gnt1,
    output logic                   rvalid1,
    output logic [bit_length-1:0]  rdata,
    output logic                   init_done,
    output logic                   sram_CEB,
    output logic                   sram_WEB,
    output logic [addr_length-1:0] sram_addr,
    output logic [bit_length-1:0]  sram_data,
    input  logic [bit_length-1:0]  sram_Q
);

    localparam int unsigned AW = addr_length;
    localparam int unsigned DW = bit_length;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state, state_d;
    logic [AW-1:0]   cnt, cnt_d;
    logic            rr, rr_d;
    logic            ceb_d, web_d;
    logic [AW-1:0]   addr_d;
    logic [DW-1:0]   data_d;
    logic            tag_v, tag_id, tag_v_d, tag_id_d;
    logic            sel, cmd_we;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;

    // Next-state, arbitration and SRAM command selection
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        rr_d      = rr;
        ceb_d     = 1'b1;
        web_d     = 1'b1;
        addr_d    = sram_addr;
        data_d    = sram_data;
        tag_v_d   = 1'b0;
        tag_id_d  = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        sel       = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;

        if (state == INIT) begin
            ceb_d  = 1'b0;
            web_d  = 1'b0;
            addr_d = cnt;
            data_d = '0;
            cnt_d  = cnt + AW'(1);
            if (cnt == '1) begin
                state_d = RUN;
            end
        end else begin
            // rr == 0 favours requester 0 when both are requesting
            gnt0 = req0 && (!req1 || !rr);
            gnt1 = req1 && !gnt0;
            sel       = gnt1;
            cmd_we    = sel ? we1    : we0;
            cmd_addr  = sel ? addr1  : addr0;
            cmd_wdata = sel ? wdata1 : wdata0;
            if (gnt0 || gnt1) begin
                ceb_d    = 1'b0;
                web_d    = ~cmd_we;
                addr_d   = cmd_addr;
                data_d   = cmd_we ? cmd_wdata : '0;
                rr_d     = ~sel;
                tag_v_d  = ~cmd_we;
                tag_id_d = sel;
            end
        end
    end

    // State, SRAM pins and the read-tag pipeline (stage 2 is rvalid0/rvalid1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            cnt       <= '0;
            rr        <= 1'b0;
            sram_CEB  <= 1'b1;
            sram_WEB  <= 1'b1;
            sram_addr <= '0;
            sram_data <= '0;
            tag_v     <= 1'b0;
            tag_id    <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            rr        <= rr_d;
            sram_CEB  <= ceb_d;
            sram_WEB  <= web_d;
            sram_addr <= addr_d;
            sram_data <= data_d;
            tag_v     <= tag_v_d;
            tag_id    <= tag_id_d;
            rvalid0   <= tag_v && !tag_id;
            rvalid1   <= tag_v && tag_id;
        end
    end

    assign init_done = (state == RUN);
    assign rdata     = sram_Q;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Self-checking bench for sram_sp_arbiter: behavioural SRAM, per-cycle model
// of pins/grants, and a read scoreboard keyed on the cycle each rvalid is due.
module tb_sram_sp_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, we0, gnt0, rvalid0;
    logic          req1, we1, gnt1, rvalid1;
    logic [AW-1:0] addr0, addr1, sram_addr;
    logic [DW-1:0] wdata0, wdata1, rdata, sram_data, sram_Q;
    logic          init_done, sram_CEB, sram_WEB;

    always #5 clk = ~clk;

    sram_sp_arbiter #(.bit_length(DW), .addr_length(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .init_done(init_done),
        .sram_CEB(sram_CEB), .sram_WEB(sram_WEB),
        .sram_addr(sram_addr), .sram_data(sram_data), .sram_Q(sram_Q)
    );

    // Single-port SRAM with registered read data
    logic [DW-1:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (!sram_CEB) begin
            if (!sram_WEB) sram_mem[sram_addr] <= sram_data;
            else           sram_Q <= sram_mem[sram_addr];
        end
    end

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
    typedef struct { logic id; logic [DW-1:0] data; int due; } rd_t;
    typedef struct { logic id; int cyc; } gl_t;
    typedef struct { logic id; logic [DW-1:0] data; } rl_t;

    cmd_t q0[$], q1[$];
    rd_t  exp_q[$];
    gl_t  glog[$];
    rl_t  rlog[$];

    logic [DW-1:0] ref_mem [DEPTH];
    int            cyc, run_cyc;
    logic          m_run, m_rr, m_ceb, m_web;
    logic [AW-1:0] m_cnt, m_addr;
    logic [DW-1:0] m_data;
    int            n_err = 0;
    int            n_chk = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Requesters present the head of their queue and hold it until granted
    initial begin
        forever begin
            @(posedge clk);
            #1;
            req0 = (q0.size() > 0);
            if (q0.size() > 0) begin we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data; end
            req1 = (q1.size() > 0);
            if (q1.size() > 0) begin we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data; end
        end
    end

    // Monitor: compare against the model, then advance it across the next edge
    always @(negedge clk) begin : mon
        logic g0, g1, id, w;
        cmd_t c;
        rd_t  r;
        if (!rst_n) begin
            chk("rst_ceb", 64'(sram_CEB), 64'(1));
            chk("rst_web", 64'(sram_WEB), 64'(1));
            chk("rst_addr", 64'(sram_addr), 64'(0));
            chk("rst_data", 64'(sram_data), 64'(0));
            chk("rst_rvalid", 64'({rvalid0, rvalid1}), 64'(0));
            chk("rst_init_done", 64'(init_done), 64'(0));
            chk("rst_gnt", 64'({gnt0, gnt1}), 64'(0));
            m_run = 1'b0; m_cnt = '0; m_rr = 1'b0;
            m_ceb = 1'b1; m_web = 1'b1; m_addr = '0; m_data = '0;
            exp_q.delete();
            for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
            cyc = 0;
            run_cyc = -1;
        end else begin
            chk("ceb", 64'(sram_CEB), 64'(m_ceb));
            chk("web", 64'(sram_WEB), 64'(m_web));
            chk("sram_addr", 64'(sram_addr), 64'(m_addr));
            chk("sram_data", 64'(sram_data), 64'(m_data));
            chk("init_done", 64'(init_done), 64'(m_run));
            if (init_done && run_cyc < 0) run_cyc = cyc;

            g0 = m_run && req0 && (!req1 || !m_rr);
            g1 = m_run && req1 && !g0;
            chk("gnt0", 64'(gnt0), 64'(g0));
            chk("gnt1", 64'(gnt1), 64'(g1));

            if (rvalid0 || rvalid1) rlog.push_back('{rvalid1, rdata});
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                r = exp_q.pop_front();
                chk("rvalid0", 64'(rvalid0), 64'(!r.id));
                chk("rvalid1", 64'(rvalid1), 64'(r.id));
                chk("rdata", 64'(rdata), 64'(r.data));
            end else begin
                chk("rvalid_idle", 64'({rvalid0, rvalid1}), 64'(0));
            end

            if (!m_run) begin
                m_ceb = 1'b0; m_web = 1'b0; m_addr = m_cnt; m_data = '0;
                if (m_cnt == AW'(DEPTH - 1)) m_run = 1'b1;
                m_cnt = m_cnt + AW'(1);
            end else if (g0 || g1) begin
                id = g1;
                c  = id ? q1.pop_front() : q0.pop_front();
                w  = c.we;
                m_ceb  = 1'b0;
                m_web  = ~w;
                m_addr = c.addr;
                m_data = w ? c.data : '0;
                m_rr   = ~id;
                if (w) ref_mem[c.addr] = c.data;
                else   exp_q.push_back('{id, ref_mem[c.addr], cyc + 2});
                glog.push_back('{id, cyc});
            end else begin
                m_ceb = 1'b1; m_web = 1'b1;
            end
            cyc++;
        end
    end

    task automatic wait_idle();
        logic busy;
        busy = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && init_done) begin
                busy = 1'b0;
                break;
            end
        end
        chk("drain_timeout", 64'(busy), 64'(0));
    endtask

    task automatic rd(input int who, input int a);
        cmd_t c;
        c = '{1'b0, AW'(a), '0};
        if (who == 0) q0.push_back(c); else q1.push_back(c);
    endtask

    initial begin
        logic [7:0] exp_ids;
        logic       seen;
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        for (int i = 0; i < int'(DEPTH); i++) sram_mem[i] = DW'($urandom) | DW'(1);

        // Requester 0 waits through zero-fill with write-then-read of addr 3
        q0.push_back('{1'b1, AW'(3), DW'(32'hA5)});
        rd(0, 3);
        rd(0, 5);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle();
        chk("init_len", 64'(run_cyc), 64'(8));
        chk("first_grants", 64'(glog.size()), 64'(3));
        if (glog.size() == 3) begin
            chk("g0_id", 64'(glog[0].id), 64'(0));
            chk("g0_cyc", 64'(glog[0].cyc), 64'(8));
            chk("g1_cyc", 64'(glog[1].cyc), 64'(9));
            chk("g2_cyc", 64'(glog[2].cyc), 64'(10));
        end
        chk("first_reads", 64'(rlog.size()), 64'(2));
        if (rlog.size() == 2) begin
            chk("hazard_data", 64'(rlog[0].data), 64'(32'hA5));
            chk("hazard_id", 64'(rlog[0].id), 64'(0));
            chk("zero_fill", 64'(rlog[1].data), 64'(0));
        end

        // Pre-write addr 1 and 2, ending with a requester 1 grant so rr favours 0
        q0.push_back('{1'b1, AW'(1), DW'(32'h1111_0001)});
        wait_idle();
        q1.push_back('{1'b1, AW'(2), DW'(32'h2222_0002)});
        wait_idle();
        glog.delete();
        rlog.delete();
        for (int i = 0; i < 3; i++) begin
            rd(0, 1);
            rd(1, 2);
        end
        wait_idle();
        chk("alt_grants", 64'(glog.size()), 64'(6));
        chk("alt_reads", 64'(rlog.size()), 64'(6));
        for (int i = 0; i < 6 && i < glog.size() && i < rlog.size(); i++) begin
            chk("alt_gnt_id", 64'(glog[i].id), 64'(i % 2));
            chk("alt_gnt_cyc", 64'(glog[i].cyc - glog[0].cyc), 64'(i));
            chk("alt_rd_id", 64'(rlog[i].id), 64'(i % 2));
            chk("alt_rd_data", 64'(rlog[i].data), (i % 2) ? 64'(32'h2222_0002) : 64'(32'h1111_0001));
        end

        // Requester 1 alone for three cycles, then both
        glog.delete();
        repeat (5) rd(1, 6);
        repeat (3) begin @(negedge clk); #1; end
        rd(0, 4);
        rd(0, 4);
        wait_idle();
        exp_ids = 8'b0101_0111;
        chk("rr_grants", 64'(glog.size()), 64'(7));
        for (int i = 0; i < 7 && i < glog.size(); i++)
            chk("rr_gnt_id", 64'(glog[i].id), 64'(exp_ids[i]));

        // Reset while a read is in flight
        glog.delete();
        rlog.delete();
        rd(0, 3);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (glog.size() > 0) begin seen = 1'b1; break; end
        end
        chk("rst_read_granted", 64'(seen), 64'(1));
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle();
        chk("reinit_len", 64'(run_cyc), 64'(8));
        chk("dropped_read", 64'(rlog.size()), 64'(0));
        rd(0, 3);
        wait_idle();
        chk("reinit_reads", 64'(rlog.size()), 64'(1));
        if (rlog.size() == 1) chk("reinit_zero", 64'(rlog[0].data), 64'(0));

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
